// File: rtl/aibcr3_dcc_crsdly_ctrl.sv
// Coarse-delay control for the DCC delay line: gray target -> binary code ->
// thermometer enable bus, with ramped/jump updates, retarget and scan/restore.
module aibcr3_dcc_crsdly_ctrl #(
  parameter int GW   = 8,
  parameter int TAPS = 2**GW,
  parameter int STEP = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [GW-1:0]   gry,
  input  logic            gry_vld,
  input  logic            ramp_en,
  input  logic            SE,
  input  logic            SI,
  output logic            SOOUT,
  output logic [TAPS-1:0] bk,
  output logic [GW-1:0]   cur_code,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SCAN} state_t;

  localparam logic [GW-1:0] STEP_G = GW'(STEP);

  state_t          r_state, w_state_n;
  logic [GW-1:0]   r_tgt, w_tgt_n;
  logic            r_mode, w_mode_n;
  logic [GW-1:0]   r_cur, w_cur_n;
  logic [TAPS-1:0] r_bk, w_bk_n;
  logic            r_busy, r_done, w_done_n;

  logic [GW-1:0]   w_gbin;
  logic [GW-1:0]   w_tgt_eff;
  logic            w_mode_eff;
  logic            w_up;
  logic [GW:0]     w_dist;
  logic [GW-1:0]   w_stp;
  logic [GW-1:0]   w_cur_step;

  function automatic logic [TAPS-1:0] therm(input logic [GW-1:0] c);
    return ~({TAPS{1'b1}} << c);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above it.
  for (genvar gi = 0; gi < GW; gi++) begin : g_g2b
    assign w_gbin[gi] = ^gry[GW-1:gi];
  end

  // A strobe in UPDATE retargets, and the step on that edge already uses it.
  assign w_tgt_eff  = gry_vld ? w_gbin  : r_tgt;
  assign w_mode_eff = gry_vld ? ramp_en : r_mode;
  assign w_up       = (w_tgt_eff >= r_cur);
  assign w_dist     = w_up ? ({1'b0, w_tgt_eff} - {1'b0, r_cur})
                           : ({1'b0, r_cur} - {1'b0, w_tgt_eff});
  assign w_stp      = (w_dist > {1'b0, STEP_G}) ? STEP_G : w_dist[GW-1:0];
  assign w_cur_step = !w_mode_eff ? w_tgt_eff
                    : (w_up ? (r_cur + w_stp) : (r_cur - w_stp));

  always_comb begin
    w_state_n = r_state;
    w_tgt_n   = r_tgt;
    w_mode_n  = r_mode;
    w_cur_n   = r_cur;
    w_bk_n    = r_bk;
    w_done_n  = 1'b0;
    if (SE) begin
      w_state_n = S_SCAN;
      w_bk_n    = {r_bk[TAPS-2:0], SI};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (gry_vld) begin
            w_tgt_n   = w_gbin;
            w_mode_n  = ramp_en;
            w_state_n = S_UPDATE;
          end
        end
        S_UPDATE: begin
          w_tgt_n  = w_tgt_eff;
          w_mode_n = w_mode_eff;
          w_cur_n  = w_cur_step;
          w_bk_n   = therm(w_cur_step);
          if (w_cur_step == w_tgt_eff) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
        end
        S_SCAN: begin
          // Restore edge: scanned contents are discarded, bus rebuilt from cur.
          w_bk_n = therm(r_cur);
          if (gry_vld) begin
            w_tgt_n   = w_gbin;
            w_mode_n  = ramp_en;
            w_state_n = S_UPDATE;
          end else begin
            w_state_n = (r_cur != r_tgt) ? S_UPDATE : S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      r_mode  <= 1'b0;
      r_cur   <= '0;
      r_bk    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tgt   <= w_tgt_n;
      r_mode  <= w_mode_n;
      r_cur   <= w_cur_n;
      r_bk    <= w_bk_n;
      r_busy  <= (w_state_n != S_IDLE);
      r_done  <= w_done_n;
    end
  end

  assign bk       = r_bk;
  assign cur_code = r_cur;
  assign busy     = r_busy;
  assign done     = r_done;
  assign SOOUT    = r_bk[TAPS-1];

endmodule

// File: tb/tb_aibcr3_dcc_crsdly_ctrl.sv
// Directed bench for the coarse-delay controller; one STEP=4 and one STEP=1
// instance share the same stimulus.
module tb_aibcr3_dcc_crsdly_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   gry = '0;
  logic         gry_vld = 1'b0;
  logic         ramp_en = 1'b0;
  logic         SE = 1'b0;
  logic         SI = 1'b0;

  logic         so4, so1;
  logic [255:0] bk4, bk1;
  logic [7:0]   cc4, cc1;
  logic         busy4, busy1, done4, done1;

  int ncmp = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  aibcr3_dcc_crsdly_ctrl #(.GW(8), .TAPS(256), .STEP(4)) dut4 (
    .CLK(CLK), .RST(RST), .gry(gry), .gry_vld(gry_vld), .ramp_en(ramp_en),
    .SE(SE), .SI(SI), .SOOUT(so4), .bk(bk4), .cur_code(cc4),
    .busy(busy4), .done(done4));

  aibcr3_dcc_crsdly_ctrl #(.GW(8), .TAPS(256), .STEP(1)) dut1 (
    .CLK(CLK), .RST(RST), .gry(gry), .gry_vld(gry_vld), .ramp_en(ramp_en),
    .SE(SE), .SI(SI), .SOOUT(so1), .bk(bk1), .cur_code(cc1),
    .busy(busy1), .done(done1));

  function automatic logic [255:0] therm(input int n);
    logic [255:0] t;
    for (int i = 0; i < 256; i++) t[i] = (i < n);
    return t;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] g, input logic r);
    gry = g; ramp_en = r; gry_vld = 1'b1;
    tick();
    gry_vld = 1'b0;
  endtask

  initial begin
    logic [255:0] cap;
    logic [255:0] pat;
    int           ndone;

    // Reset and jump
    tick(); tick();
    chk("rst_bk", bk4, '0);
    chk("rst_cur", cc4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_so", so4, 0);
    RST = 1'b0;
    strobe(8'hC0, 1'b0);
    chk("jmp_busy_e0", busy4, 1);
    chk("jmp_done_e0", done4, 0);
    tick();
    chk("jmp_cur", cc4, 128);
    chk("jmp_bk", bk4, {128'h0, {128{1'b1}}});
    chk("jmp_done", done4, 1);
    chk("jmp_busy", busy4, 0);
    tick();
    chk("jmp_done_clr", done4, 0);

    // Ramp up 0 -> 10 with STEP=4
    RST = 1'b1; tick(); RST = 1'b0;
    strobe(8'h0F, 1'b1);
    chk("rmp_busy_e0", busy4, 1);
    tick();
    chk("rmp_cur1", cc4, 4);
    chk("rmp_bk1", bk4, therm(4));
    chk("rmp_s1_cur1", cc1, 1);
    tick();
    chk("rmp_cur2", cc4, 8);
    chk("rmp_bk2", bk4, therm(8));
    chk("rmp_done2", done4, 0);
    chk("rmp_busy2", busy4, 1);
    tick();
    chk("rmp_cur3", cc4, 10);
    chk("rmp_bk3", bk4, therm(10));
    chk("rmp_done3", done4, 1);
    chk("rmp_busy3", busy4, 0);

    // Retarget on the STEP=1 instance: 0 -> 200, then 20 at cur=50
    RST = 1'b1; tick(); RST = 1'b0;
    strobe(8'hAC, 1'b1);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      ndone += int'(done1);
    end
    chk("rt_cur50", cc1, 50);
    chk("rt_nodone_up", ndone, 0);
    strobe(8'h1E, 1'b1);
    chk("rt_cur49", cc1, 49);
    chk("rt_busy49", busy1, 1);
    ndone = 0;
    for (int i = 0; i < 28; i++) begin
      tick();
      ndone += int'(done1);
    end
    chk("rt_cur21", cc1, 21);
    chk("rt_nodone_dn", ndone, 0);
    tick();
    chk("rt_cur20", cc1, 20);
    chk("rt_bk20", bk1, therm(20));
    chk("rt_done20", done1, 1);
    chk("rt_busy20", busy1, 0);
    tick();
    chk("rt_done_clr", done1, 0);

    // Scan with cur=3; a strobe mid-scan must be ignored
    RST = 1'b1; tick(); RST = 1'b0;
    strobe(8'h02, 1'b0);
    tick(); tick();
    chk("sc_cur3", cc4, 3);
    SE = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cap[i] = so4;
      SI = ((i % 2) == 0);
      gry_vld = (i == 10);
      gry = 8'h80;
      tick();
      if (i == 100) begin
        chk("sc_busy", busy4, 1);
        chk("sc_done", done4, 0);
        chk("sc_cur_frozen", cc4, 3);
      end
    end
    gry_vld = 1'b0;
    pat = {128{2'b10}};
    chk("sc_sout", cap, {3'b111, 253'h0});
    chk("sc_bk_shift", bk4, pat);
    chk("sc_sout_last", so4, 1);
    SE = 1'b0;
    tick();
    chk("rs_bk", bk4, therm(3));
    chk("rs_cur", cc4, 3);
    chk("rs_done", done4, 0);
    chk("rs_busy", busy4, 0);

    // Maximum code, jump mode
    strobe(8'h80, 1'b0);
    tick();
    chk("max_cur", cc4, 255);
    chk("max_bk", bk4, {1'b0, {255{1'b1}}});
    chk("max_so", so4, 0);
    chk("max_done", done4, 1);
    tick();

    // Target equal to current
    strobe(8'h80, 1'b1);
    chk("eq_busy_e0", busy4, 1);
    tick();
    chk("eq_done", done4, 1);
    chk("eq_busy", busy4, 0);
    chk("eq_bk", bk4, {1'b0, {255{1'b1}}});
    tick();

    // Reset mid-ramp down
    strobe(8'h00, 1'b1);
    tick(); tick();
    chk("mr_cur", cc4, 247);
    chk("mr_busy", busy4, 1);
    RST = 1'b1;
    tick();
    chk("mr_bk", bk4, '0);
    chk("mr_cur0", cc4, 0);
    chk("mr_busy0", busy4, 0);
    chk("mr_done0", done4, 0);
    chk("mr_cur1_0", cc1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/aibcr3_dcc_crsdly_ctrl.md
# aibcr3_dcc_crsdly_ctrl

Parametrised coarse-delay control block for the DCC coarse delay line. It takes a gray-coded delay setting, converts it to binary, and drives a TAPS-wide thermometer enable bus `bk` for the cascaded delay-cell segments. Unlike the fixed 256-tap combinational decoder, it supports:
- configurable tap count;
- glitch-safe ramped updates with a bounded per-cycle tap change;
- retargeting while a ramp is in progress;
- a busy/done handshake;
- a scan chain through the thermometer register with state restore.

## Interface
Parameters:
- `GW`, 8, width of the gray/binary code.
- `TAPS`, 2**GW, number of thermometer taps (delay cells). Must equal 2**GW.
- `STEP`, 1, maximum number of taps changed per cycle in ramp mode (1..TAPS-1).

Ports:
- `CLK`  in  1  block clock; all state changes on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `gry`  in  GW  target delay setting, gray-coded.
- `gry_vld`  in  1  strobe; `gry` is sampled on any edge where `gry_vld`=1 and `SE`=0.
- `ramp_en`  in  1  update mode: 1 = ramp by ≤`STEP` taps per cycle; 0 = jump in one cycle. Sampled together with `gry`.
- `SE`  in  1  scan enable.
- `SI`  in  1  scan input.
- `SOOUT`  out  1  scan output; always equals `bk[TAPS-1]`.
- `bk`  out  TAPS  registered thermometer bus; in functional mode `bk[i]`=1 iff i < `cur_code`.
- `cur_code`  out  GW  registered binary code currently applied to `bk`.
- `busy`  out  1  registered; high while an update is pending or in progress.
- `done`  out  1  registered; one-cycle pulse when `cur_code` reaches the target.

## Operation
Gray-to-binary conversion:
- `b[GW-1]` = `g[GW-1]`
- `b[i]` = `b[i+1]` ^ `g[i]`

Internal registers: `tgt` (GW bits), `mode` (1 bit), `cur` (GW bits, drives `cur_code`), the `bk` register, and an FSM.

FSM states:
- **IDLE**
  - `busy`=0.
  - `gry_vld` → capture `tgt`=g2b(`gry`) and `mode`=`ramp_en`; go to UPDATE.
- **UPDATE**
  - `busy`=1.
  - Each edge: `cur` moves toward `tgt`.
    - jump mode: `cur`=`tgt`.
    - ramp mode: `cur` ± min(`STEP`, |`tgt`−`cur`|).
  - `bk` is rewritten from the new `cur` on the same edge.
  - Go to IDLE on the edge where the new `cur` equals `tgt`; that edge also sets `done`=1 for exactly one cycle.
  - If `tgt`==`cur` on entry, one UPDATE edge still occurs (`bk` unchanged) and `done` pulses.
  - Down-ramps are symmetric to up-ramps.
  - Subtraction is on an unsigned (GW+1)-bit difference; `cur` never over- or undershoots `tgt`.
- **Retarget:** `gry_vld` while in UPDATE recaptures `tgt` and `mode` on that edge, and the step on that edge uses the new target. No `done` is issued for the abandoned target.
- **SCAN** (entered from any state when `SE`=1)
  - `bk` <= {`bk[TAPS-2:0]`, `SI`} each edge.
  - `cur`, `tgt` and `mode` are frozen; `gry_vld` is ignored.
  - `busy`=1, `done`=0.
- **RESTORE** (first edge with `SE`=0 after SCAN)
  - `bk` is reloaded from therm(`cur`).
  - Then go to UPDATE if `cur`≠`tgt`, else to IDLE with no `done` pulse.
- **Priority:** `RST` > `SE` > `gry_vld` > ramp step.

## Timing
- **Reset** (edge with `RST`=1, regardless of `SE`):
  - `bk`=0, `cur_code`=0, `tgt`=0, `busy`=0, `done`=0, `SOOUT`=0.
  - FSM to IDLE.
  - Asserting `RST` mid-ramp or mid-scan aborts immediately.
- **Jump mode:**
  - Capture at edge E0; `busy`=1 after E0.
  - `bk`/`cur_code` final after E1; `done`=1 and `busy`=0 in the cycle after E1.
  - Latency is 1 cycle from capture.
- **Ramp mode**, distance D = |`tgt`−`cur`|:
  - Steps occur at E1..EK, where K = max(1, ceil(D/STEP)).
  - `busy` is high from after E0 through the cycle before EK.
  - `done` pulses in the cycle after EK.
- **Monotonicity:** `bk` never changes by more than `STEP` bits per edge in ramp mode. Every intermediate value is a valid thermometer code.
- **Range:**
  - Maximum code is TAPS−1 (`bk[TAPS-2:0]` all ones, `bk[TAPS-1]`=0 in functional mode).
  - No wrap-around.
- **Scan:** `SOOUT` is combinational from the `bk` register, with no extra flop. After N shift edges, `SOOUT` presents the bit originally at `bk[TAPS-1-N]`.

## Test plan
- **Reset and jump:**
  - Assert `RST` 2 cycles → all outputs 0.
  - Then `gry`=8'hC0, `ramp_en`=0, `gry_vld` for 1 cycle → after E1, `cur_code`=128, `bk[127:0]` all ones, `bk[255:128]`=0; `done` is a single pulse; `busy` high for exactly 1 cycle.
- **Ramp up** (`STEP`=4): from 0, target binary 10 (`gry`=8'h0F) → `cur_code` is 4, 8, 10 on successive edges; `done` pulses after the third edge; each `bk` step changes ≤4 bits.
- **Retarget:** ramp from 0 to 200 with `STEP`=1; at `cur_code`=50, strobe target 20 → `cur_code` goes 49 on the retarget edge, then descends to 20; `done` pulses exactly once, only at 20.
- **Scan:**
  - Sequence: with `cur_code`=3, assert `SE` for 256 cycles shifting in the pattern 1,0,1,0,…; capture `SOOUT`; then deassert `SE`.
  - Required response: `SOOUT` shows 253 zeros then 3 ones; after the RESTORE edge, `bk`=therm(3); no `done` pulse.
- **Boundaries and reset mid-ramp:**
  - Target 255 (`gry`=8'h80) in jump mode → `bk` = 255 ones plus `bk[255]`=0.
  - Target equal to current → `busy` for 1 cycle, `done` pulse, `bk` unchanged.
  - `RST` mid-ramp → all outputs 0 on the next edge.
